// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between icache refill and the LSU,
// serialising 1/2/4-byte accesses little-endian with round-robin arbitration.
module mem_arbiter #(
    parameter logic [31:0] IO_MASK = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
    state_t state, state_n;
    logic [31:0] addr, addr_n, wdata, wdata_n, data, data_n, merged;
    logic [31:0] if_data_n, ls_rdata_n, mem_a_n;
    logic [7:0]  mem_dout_n;
    logic [2:0]  len, len_n, cnt, cnt_n, ls_len;
    logic [1:0]  rd_idx;
    logic        last_ls, last_ls_n, if_done_n, ls_done_n, mem_wr_n;
    logic        grant_if, grant_ls, io_stall, ls_io_stall;

    assign ls_len      = ls_size == 2'd0 ? 3'd1 : ls_size == 2'd1 ? 3'd2 : 3'd4;
    assign grant_if    = if_req && (!ls_req || last_ls);
    assign grant_ls    = ls_req && !grant_if;
    assign io_stall    = io_buffer_full && ((addr & IO_MASK) == IO_MASK);
    assign ls_io_stall = io_buffer_full && ((ls_addr & IO_MASK) == IO_MASK);
    // cnt counts bytes already issued, so the byte arriving now is cnt-1
    assign rd_idx      = cnt[1:0] - 2'd1;

    always_comb begin
        merged = data;
        merged[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        wdata_n    = wdata;
        data_n     = data;
        len_n      = len;
        cnt_n      = cnt;
        last_ls_n  = last_ls;
        if_done_n  = if_done;
        if_data_n  = if_data;
        ls_done_n  = ls_done;
        ls_rdata_n = ls_rdata;
        mem_a_n    = mem_a;
        mem_dout_n = mem_dout;
        mem_wr_n   = mem_wr;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_n   = IF_RD;
                    addr_n    = if_addr;
                    len_n     = 3'd4;
                    cnt_n     = 3'd1;
                    data_n    = '0;
                    last_ls_n = 1'b0;
                    mem_a_n   = if_addr;
                    mem_wr_n  = 1'b0;
                end else if (grant_ls) begin
                    addr_n    = ls_addr;
                    wdata_n   = ls_wdata;
                    len_n     = ls_len;
                    data_n    = '0;
                    last_ls_n = 1'b1;
                    state_n   = ls_we ? LS_WR : LS_RD;
                    cnt_n     = ls_we && ls_io_stall ? 3'd0 : 3'd1;
                    mem_a_n   = ls_we && ls_io_stall ? mem_a : ls_addr;
                    mem_dout_n = ls_we ? ls_wdata[7:0] : mem_dout;
                    mem_wr_n  = ls_we && !ls_io_stall;
                end
            end
            IF_RD, LS_RD: begin
                if (flush) begin
                    state_n = IDLE;
                    mem_a_n = '0;
                end else if (cnt == len) begin
                    state_n    = DONE;
                    mem_a_n    = '0;
                    if_done_n  = state == IF_RD;
                    ls_done_n  = state == LS_RD;
                    if_data_n  = state == IF_RD ? merged : if_data;
                    ls_rdata_n = state == LS_RD ? merged : ls_rdata;
                end else begin
                    data_n  = merged;
                    mem_a_n = addr + 32'(cnt);
                    cnt_n   = cnt + 3'd1;
                end
            end
            LS_WR: begin
                if (cnt == len) begin
                    state_n   = DONE;
                    ls_done_n = 1'b1;
                    mem_wr_n  = 1'b0;
                    mem_a_n   = '0;
                end else if (io_stall) begin
                    mem_wr_n = 1'b0;
                end else begin
                    mem_a_n    = addr + 32'(cnt);
                    mem_dout_n = wdata[{cnt[1:0], 3'b000} +: 8];
                    mem_wr_n   = 1'b1;
                    cnt_n      = cnt + 3'd1;
                end
            end
            DONE: begin
                state_n   = IDLE;
                if_done_n = 1'b0;
                ls_done_n = 1'b0;
                cnt_n     = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            wdata    <= '0;
            data     <= '0;
            len      <= '0;
            cnt      <= '0;
            last_ls  <= 1'b1;
            if_done  <= 1'b0;
            if_data  <= '0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
        end else if (rdy) begin
            state    <= state_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            data     <= data_n;
            len      <= len_n;
            cnt      <= cnt_n;
            last_ls  <= last_ls_n;
            if_done  <= if_done_n;
            if_data  <= if_data_n;
            ls_done  <= ls_done_n;
            ls_rdata <= ls_rdata_n;
            mem_a    <= mem_a_n;
            mem_dout <= mem_dout_n;
            mem_wr   <= mem_wr_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a shadow-memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst, rdy, flush, if_req, ls_req, ls_we, io_buffer_full;
    logic        if_done, ls_done, mem_wr;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic [7:0]  ram [4096];
    logic [7:0]  shadow [4096];
    logic [39:0] wlog [$];
    int          cyc = 0, n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    assign mem_din = ram[mem_a[11:0]];

    function automatic bit is_io(input logic [31:0] a);
        return (a & 32'h0003_0000) == 32'h0003_0000;
    endfunction

    // RAM device: writes land at the edge, IO writes go to the (unmodelled) UART
    always @(posedge clk) begin
        cyc++;
        if (rst && rdy && mem_wr) begin
            wlog.push_back({mem_a, mem_dout});
            if (!is_io(mem_a)) ram[mem_a[11:0]] = mem_dout;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_read(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        logic [31:0] b;
        for (int k = 0; k < n; k++) begin
            b = a + 32'(k);
            r = r | (32'(shadow[b[11:0]]) << (8 * k));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access from one port; flush/rdy are pulsed relative to the grant edge.
    task automatic txn(input bit is_if, input bit we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int flush_at, input int freeze_at,
                       input int freeze_len, input string tag);
        int n, i;
        logic [31:0] b;
        n = is_if ? 4 : (sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4);
        wlog.delete();
        if (is_if) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        end
        step();
        check({tag, " grant addr"}, mem_a, a);
        i = 0;
        while (i < 40 && !(is_if ? if_done : ls_done)) begin
            flush = (i == flush_at);
            rdy = !(i >= freeze_at && i < freeze_at + freeze_len);
            step();
            i++;
        end
        flush = 1'b0; rdy = 1'b1; if_req = 1'b0; ls_req = 1'b0;
        check({tag, " latency"}, 64'(i), 64'(n + freeze_len));
        if (we) begin
            check({tag, " write count"}, 64'(wlog.size()), 64'(n));
            for (int k = 0; k < n && k < wlog.size(); k++) begin
                b = a + 32'(k);
                check($sformatf("%s write byte %0d", tag, k), wlog[k], {b, 8'((wd >> (8 * k)) & 32'hFF)});
                if (!is_io(b)) shadow[b[11:0]] = 8'((wd >> (8 * k)) & 32'hFF);
            end
        end else begin
            check({tag, " data"}, is_if ? if_data : ls_rdata, expect_read(a, n));
        end
        step();
        check({tag, " done width"}, is_if ? if_done : ls_done, 0);
    endtask

    // Both ports request together; the LSU does a byte load.
    task automatic pair(input logic [31:0] ia, input logic [31:0] la, input bit if_first, input string tag);
        bit ip = 1'b1, lp = 1'b1;
        int i = 0, first = -1;
        logic [31:0] ie, le;
        ie = expect_read(ia, 4);
        le = expect_read(la, 1);
        if_req = 1'b1; if_addr = ia;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = la;
        step();
        check({tag, " first grant addr"}, mem_a, if_first ? ia : la);
        while ((ip || lp) && i < 40) begin
            if (ip && if_done) begin
                check({tag, " if_data"}, if_data, ie);
                ip = 1'b0; if_req = 1'b0;
                if (first < 0) first = 0;
            end
            if (lp && ls_done) begin
                check({tag, " ls_rdata"}, ls_rdata, le);
                lp = 1'b0; ls_req = 1'b0;
                if (first < 0) first = 1;
            end
            step();
            i++;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check({tag, " completion order"}, 64'(first), if_first ? 64'd0 : 64'd1);
        check({tag, " both served"}, {ip, lp}, 2'b00);
    endtask

    initial begin
        int op, n, fa, fl;
        logic [1:0] sz;
        logic [31:0] a, wd;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            shadow[i] = ram[i];
        end
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        io_buffer_full = 1'b0; ls_size = 2'd0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_a", mem_a, 0);
        check("reset mem_wr", mem_wr, 0);
        check("reset dones", {if_done, ls_done}, 0);
        rst = 1'b1;
        step();

        // tie right after reset goes to IF; after an IF-only fetch the next tie goes to LSU
        pair(32'h40, 32'h8, 1'b1, "tie after reset");
        txn(1'b1, 1'b0, 2'd2, 32'h80, 0, -1, -1, 0, "if alone");
        pair(32'h44, 32'h9, 1'b0, "tie after if");

        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        for (int i = 12'h100; i < 12'h104; i++) shadow[i] = ram[i];
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("fetch mem_a byte %0d", k), {mem_wr, mem_a}, {1'b0, 32'h100 + 32'(k)});
        end
        step();
        check("fetch done", if_done, 1);
        check("fetch data", if_data, 32'h4433_2211);
        if_req = 1'b0;
        step();
        check("fetch done width", if_done, 0);

        txn(1'b0, 1'b1, 2'd1, 32'h200, 32'h0000_BEEF, -1, -1, 0, "store half");
        txn(1'b0, 1'b0, 2'd1, 32'h200, 0, -1, -1, 0, "reload half");

        wlog.delete();
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h5A;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("io stall cycle %0d", k), {ls_done, mem_wr}, 2'b00);
        end
        io_buffer_full = 1'b0;
        step();
        check("io write issued", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h5A});
        step();
        check("io store done", {ls_done, mem_wr, mem_a}, {1'b1, 1'b0, 32'h0});
        ls_req = 1'b0;
        check("io write count", 64'(wlog.size()), 1);
        step();

        if_req = 1'b1; if_addr = 32'h104;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; if_req = 1'b0;
        check("flushed fetch", {if_done, mem_a}, {1'b0, 32'h0});
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("no done after flush %0d", k), if_done, 0);
        end
        txn(1'b0, 1'b0, 2'd2, 32'h120, 0, -1, -1, 0, "load after flush");
        txn(1'b0, 1'b1, 2'd2, 32'h280, 32'hCAFE_F00D, 1, -1, 0, "flush during store");
        txn(1'b0, 1'b0, 2'd2, 32'h280, 0, -1, -1, 0, "reload flushed store");
        txn(1'b0, 1'b0, 2'd2, 32'h300, 0, -1, 1, 4, "freeze load");
        txn(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 0, -1, -1, 0, "wrap fetch");
        txn(1'b0, 1'b1, 2'd3, 32'h3FE, 32'h0102_0304, -1, -1, 0, "size3 store");

        if_req = 1'b1; if_addr = 32'h100;
        step();
        step();
        rst = 1'b0;
        #1;
        check("async reset mem", {mem_wr, mem_a, mem_dout}, 0);
        check("async reset data", {if_done, ls_done, if_data, ls_rdata}, 0);
        if_req = 1'b0;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("no done after reset %0d", k), if_done, 0);
        end
        pair(32'h48, 32'hA, 1'b1, "tie after async reset");

        for (int r = 0; r < 30; r++) begin
            op = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            wd = $urandom;
            n = op == 0 ? 4 : (sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4);
            fl = $urandom_range(0, 1) ? $urandom_range(1, 3) : 0;
            fa = $urandom_range(0, n - 1);
            io_buffer_full = (op == 2 && is_io(a)) ? 1'b0 : 1'($urandom_range(0, 1));
            txn(op == 0, op == 2, sz, a, wd, -1, fa, fl, $sformatf("rand%0d", r));
            io_buffer_full = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
